// File: rtl/msg_byte_coder.sv
// Manchester line coder: one byte per d_rdy handshake, framed as start, d[7:0] MSB first, stop.
// Define MSG_CODER_PARITY_EN to insert an odd-parity bit before the stop bit.
module msg_byte_coder #(
    parameter int HALF_BIT_CLKS = 4,
    parameter int GAP_CLKS      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d,
    input  logic       d_rdy,
    output logic       busy,
    output logic       line,
    output logic       line_oe,
    output logic       frame_done
);

`ifdef MSG_CODER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int HW = $clog2(HALF_BIT_CLKS + 1);
    localparam int GW = $clog2(GAP_CLKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [NBITS-1:0] shreg;
    logic [HW-1:0]    half_cnt;
    logic             phase;
    logic [3:0]       bit_cnt;
    logic [GW-1:0]    gap_cnt;

    logic [NBITS-1:0] frame_load;
    logic             half_wrap;
    logic             bit_end;
    logic             last_cycle;
    logic [HW-1:0]    half_nxt;
    logic             phase_nxt;
    logic [3:0]       bit_nxt;
    logic [NBITS-1:0] shreg_nxt;
    logic             line_nxt;
    logic             done_nxt;

`ifdef MSG_CODER_PARITY_EN
    assign frame_load = {1'b0, d, ~^d, 1'b1};
`else
    assign frame_load = {1'b0, d, 1'b1};
`endif

    // Position of the next cycle; line and frame_done are registered from it so they stay glitch-free.
    assign half_wrap  = (half_cnt == HW'(HALF_BIT_CLKS - 1));
    assign bit_end    = half_wrap & phase;
    assign last_cycle = bit_end & (bit_cnt == 4'(NBITS - 1));
    assign half_nxt   = half_wrap ? '0 : half_cnt + HW'(1);
    assign phase_nxt  = phase ^ half_wrap;
    assign bit_nxt    = bit_end ? bit_cnt + 4'd1 : bit_cnt;
    assign shreg_nxt  = bit_end ? {shreg[NBITS-2:0], 1'b0} : shreg;
    assign line_nxt   = phase_nxt ? shreg_nxt[NBITS-1] : ~shreg_nxt[NBITS-1];
    assign done_nxt   = (bit_nxt == 4'(NBITS - 1)) & phase_nxt
                        & (half_nxt == HW'(HALF_BIT_CLKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            half_cnt   <= '0;
            phase      <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            line       <= 1'b1;
            line_oe    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                SEND: begin
                    if (last_cycle) begin
                        state      <= GAP;
                        half_cnt   <= '0;
                        phase      <= 1'b0;
                        bit_cnt    <= '0;
                        gap_cnt    <= '0;
                        busy       <= 1'b0;
                        line       <= 1'b1;
                        line_oe    <= 1'b0;
                        frame_done <= 1'b0;
                    end else begin
                        half_cnt   <= half_nxt;
                        phase      <= phase_nxt;
                        bit_cnt    <= bit_nxt;
                        shreg      <= shreg_nxt;
                        line       <= line_nxt;
                        frame_done <= done_nxt;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_CLKS - 1)) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                // IDLE, and the unreachable encoding 3 which recovers as IDLE.
                default: begin
                    busy       <= 1'b0;
                    line       <= 1'b1;
                    line_oe    <= 1'b0;
                    frame_done <= 1'b0;
                    half_cnt   <= '0;
                    phase      <= 1'b0;
                    bit_cnt    <= '0;
                    gap_cnt    <= '0;
                    if (d_rdy) begin
                        state   <= SEND;
                        shreg   <= frame_load;
                        busy    <= 1'b1;
                        line_oe <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_byte_coder.sv
// Directed bench for msg_byte_coder; frame bit patterns are hand-computed constants.
// Works in both the default build and with MSG_CODER_PARITY_EN defined.
module tb_msg_byte_coder;

    localparam int HALF = 4;
    localparam int GAPC = 2;
`ifdef MSG_CODER_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] F_A5 = 11'b0_10100101_1_1;
    localparam logic [10:0] F_FF = 11'b0_11111111_1_1;
    localparam logic [10:0] F_00 = 11'b0_00000000_1_1;
    localparam logic [10:0] F_7E = 11'b0_01111110_1_1;
    localparam logic [10:0] F_3C = 11'b0_00111100_1_1;
`else
    localparam int NB = 10;
    localparam logic [10:0] F_A5 = 11'b0_0_10100101_1;
    localparam logic [10:0] F_FF = 11'b0_0_11111111_1;
    localparam logic [10:0] F_00 = 11'b0_0_00000000_1;
    localparam logic [10:0] F_7E = 11'b0_0_01111110_1;
    localparam logic [10:0] F_3C = 11'b0_0_00111100_1;
`endif
    localparam int FRAME_CYC = NB * 2 * HALF;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       d_rdy = 1'b0;
    logic [7:0] d     = 8'h00;
    logic       busy;
    logic       line;
    logic       line_oe;
    logic       frame_done;

    int   vectors     = 0;
    int   miscompares = 0;
    int   doneCount   = 0;
    int   riseCount   = 0;
    logic busyPrev    = 1'b0;

    always #5 clk = ~clk;

    msg_byte_coder #(.HALF_BIT_CLKS(HALF), .GAP_CLKS(GAPC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .d_rdy      (d_rdy),
        .busy       (busy),
        .line       (line),
        .line_oe    (line_oe),
        .frame_done (frame_done)
    );

    always @(negedge clk) begin
        if (frame_done === 1'b1) doneCount++;
        if (busy === 1'b1 && busyPrev !== 1'b1) riseCount++;
        busyPrev = busy;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] val);
        @(negedge clk);
        d     = val;
        d_rdy = 1'b1;
        @(negedge clk);
        d_rdy = 1'b0;
        d     = ~val;
    endtask

    task automatic waitBusy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_start"}, 32'(busy), 32'd1);
    endtask

    // Checks {busy,line_oe,line,frame_done} on every cycle of a frame, then the first GAP cycle.
    task automatic frameCheck(input string tag, input logic [10:0] bits);
        logic b;
        logic expLine;
        waitBusy(tag);
        for (int k = 0; k < FRAME_CYC; k++) begin
            b       = bits[NB - 1 - k / (2 * HALF)];
            expLine = (((k / HALF) % 2) == 1) ? b : ~b;
            checkOutput($sformatf("%s_c%0d", tag, k),
                        32'({busy, line_oe, line, frame_done}),
                        32'({1'b1, 1'b1, expLine, (k == FRAME_CYC - 1)}));
            @(negedge clk);
        end
        checkOutput({tag, "_end"}, 32'({busy, line_oe, line, frame_done}), 32'b0010);
    endtask

    initial begin
        int low;
        int riseBefore;
        int doneBefore;

        // Reset held with d_rdy high, then the first edge after release starts a frame.
        d     = 8'hA5;
        d_rdy = 1'b1;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_outputs", 32'({busy, line_oe, line, frame_done}), 32'b0010);
        rst_n = 1'b1;
        #1 checkOutput("release_no_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 checkOutput("busy_after_first_edge", 32'(busy), 32'd1);
        @(negedge clk);
        d_rdy = 1'b0;
        frameCheck("rst_frame", F_A5);
        repeat (3) @(negedge clk);

        applyStimulus(8'hA5);
        frameCheck("a5", F_A5);
        repeat (3) @(negedge clk);

        applyStimulus(8'hFF);
        frameCheck("ff", F_FF);
        repeat (3) @(negedge clk);

        applyStimulus(8'h00);
        frameCheck("zero", F_00);
        repeat (3) @(negedge clk);

        // Back-to-back frames with d_rdy held high.
        @(negedge clk);
        d          = 8'h7E;
        d_rdy      = 1'b1;
        riseBefore = riseCount;
        frameCheck("b2b_1", F_7E);
        low = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy === 1'b1) break;
            low++;
        end
        d_rdy = 1'b0;
        checkOutput("b2b_gap_low", 32'(low), 32'(GAPC + 1));
        frameCheck("b2b_2", F_7E);
        repeat (5) @(negedge clk);
        checkOutput("b2b_rises", 32'(riseCount - riseBefore), 32'd2);

        // Reset asserted mid-frame aborts immediately without a frame_done pulse.
        applyStimulus(8'h3C);
        repeat (30) @(negedge clk);
        doneBefore = doneCount;
        #2 rst_n = 1'b0;
        #1 checkOutput("abort_outputs", 32'({busy, line_oe, line, frame_done}), 32'b0010);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME_CYC) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("abort_idle", 32'(busy), 32'd0);
        applyStimulus(8'h3C);
        frameCheck("post_abort", F_3C);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
